// File: rtl/command_dispatcher.sv
// command_dispatcher: turns a header+payload command stream into engine start pulses and graphics register writes.
// Define CMD_DISPATCH_TIMEOUT_EN to add a WAIT watchdog that reports err_code 3 after TIMEOUT_CYC cycles.
module command_dispatcher #(
    parameter int NUM_ENGINES = 4,
    parameter int MAX_PAYLOAD = 8,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    input  logic [31:0]               cmd_data,
    output logic                      cmd_ready,
    output logic [NUM_ENGINES-1:0]    eng_start,
    input  logic [NUM_ENGINES-1:0]    eng_done,
    output logic [MAX_PAYLOAD*32-1:0] payload,
    output logic [15:0]               payload_len,
    output logic [31:0]               color,
    output logic [31:0]               vp_xmin,
    output logic [31:0]               vp_ymin,
    output logic [31:0]               vp_xmax,
    output logic [31:0]               vp_ymax,
    output logic                      busy,
    output logic                      err_valid,
    output logic [1:0]                err_code,
    output logic [15:0]               cmd_count
);
    typedef enum logic [2:0] {IDLE, READ, DRAIN, START, WAIT} state_t;
    // Buffer is at least 4 words so the viewport write never indexes past it.
    localparam int PW = MAX_PAYLOAD < 4 ? 4 : MAX_PAYLOAD;
    localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);
    localparam logic [7:0] OP_COLOR = 8'h10;
    localparam logic [7:0] OP_VIEWPORT = 8'h11;

    state_t state, state_nx;
    logic [7:0] op;
    logic [15:0] len, cnt;
    logic [31:0] words [PW];
    logic [NUM_ENGINES-1:0] eng_sel;
    logic hs, hdr_legal, is_eng, set_short, timeout, unused_hdr;

    assign cmd_ready = state == IDLE || state == READ || (state == DRAIN && cnt < len);
    assign hs = cmd_valid & cmd_ready;
    assign busy = state != IDLE;
    assign unused_hdr = ^cmd_data[23:16];
    assign is_eng = |eng_sel;
    assign set_short = (op == OP_COLOR && len == 16'd0) || (op == OP_VIEWPORT && len < 16'd4);
    assign hdr_legal = (cmd_data[31:24] != 8'd0 && cmd_data[31:24] <= 8'(NUM_ENGINES)) ||
                       cmd_data[31:24] == OP_COLOR || cmd_data[31:24] == OP_VIEWPORT;

    always_comb begin
        eng_sel = '0;
        for (int i = 0; i < NUM_ENGINES; i++) eng_sel[i] = op == 8'(i + 1);
    end

    for (genvar g = 0; g < MAX_PAYLOAD; g++) begin : g_payload
        assign payload[g*32 +: 32] = words[g];
    end

`ifdef CMD_DISPATCH_TIMEOUT_EN
    logic [31:0] timer;
    assign timeout = timer == 32'(TIMEOUT_CYC);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) timer <= '0;
        else timer <= state == WAIT ? timer + 32'd1 : '0;
`else
    logic unused_timeout;
    assign timeout = 1'b0;
    assign unused_timeout = |TIMEOUT_CYC;
`endif

    always_comb begin
        state_nx = state;
        eng_start = '0;
        err_valid = 1'b0;
        err_code = 2'd0;
        case (state)
            IDLE: if (hs) state_nx = (!hdr_legal || cmd_data[15:0] > MAX_LEN) ? DRAIN :
                                     cmd_data[15:0] == 16'd0 ? START : READ;
            READ: if (hs && cnt == len - 16'd1) state_nx = START;
            DRAIN: if (cnt == len) begin
                state_nx = IDLE;
                err_valid = 1'b1;
                err_code = len > MAX_LEN ? 2'd1 : 2'd2;
            end
            START: begin
                eng_start = eng_sel;
                state_nx = is_eng ? WAIT : IDLE;
                err_valid = set_short;
                err_code = set_short ? 2'd2 : 2'd0;
            end
            WAIT: if (|(eng_done & eng_sel)) state_nx = IDLE;
                  else if (timeout) begin
                      state_nx = IDLE;
                      err_valid = 1'b1;
                      err_code = 2'd3;
                  end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            op <= '0;
            len <= '0;
            cnt <= '0;
            payload_len <= '0;
            cmd_count <= '0;
            color <= '0;
            vp_xmin <= '0;
            vp_ymin <= '0;
            vp_xmax <= '0;
            vp_ymax <= '0;
            for (int i = 0; i < PW; i++) words[i] <= '0;
        end else begin
            state <= state_nx;
            if (busy && state_nx == IDLE) cmd_count <= cmd_count + 16'd1;
            if (state == IDLE && hs) begin
                op <= cmd_data[31:24];
                len <= cmd_data[15:0];
                cnt <= '0;
                payload_len <= '0;
            end
            if ((state == READ || state == DRAIN) && hs) cnt <= cnt + 16'd1;
            if (state == READ && hs) begin
                payload_len <= cnt + 16'd1;
                for (int i = 0; i < PW; i++) if (cnt == 16'(i)) words[i] <= cmd_data;
            end
            if (state == START && !set_short && op == OP_COLOR) color <= words[0];
            if (state == START && !set_short && op == OP_VIEWPORT) begin
                vp_xmin <= words[0];
                vp_ymin <= words[1];
                vp_xmax <= words[2];
                vp_ymax <= words[3];
            end
        end
endmodule

// File: tb/tb_command_dispatcher.sv
// tb_command_dispatcher: table, hand-written and randomized command sequences checked against a
// transaction-level model of the dispatcher (NUM_ENGINES=4, MAX_PAYLOAD=8, TIMEOUT_CYC=100).
module tb_command_dispatcher;
    typedef struct {
        logic [31:0] hdr;
        logic [1:0]  err;
        logic [3:0]  start;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cmd_valid = 1'b0;
    logic [31:0] cmd_data = '0;
    logic cmd_ready;
    logic [3:0] eng_start;
    logic [3:0] eng_done = '0;
    logic [255:0] payload;
    logic [15:0] payload_len, cmd_count;
    logic [31:0] color, vp_xmin, vp_ymin, vp_xmax, vp_ymax;
    logic busy, err_valid;
    logic [1:0] err_code;

    int checks = 0;
    int failures = 0;
    int starts = 0;
    int errs = 0;
    logic [3:0] last_start = '0;
    logic [1:0] last_err = '0;
    logic [31:0] m_color, m_vp [4], m_words [8];
    logic [31:0] wq [$];
    logic [15:0] m_count, m_len;
    vec_t vt [13];

    always #5 clk = ~clk;

    command_dispatcher #(.NUM_ENGINES(4), .MAX_PAYLOAD(8), .TIMEOUT_CYC(100)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
        .eng_start(eng_start), .eng_done(eng_done), .payload(payload), .payload_len(payload_len),
        .color(color), .vp_xmin(vp_xmin), .vp_ymin(vp_ymin), .vp_xmax(vp_xmax), .vp_ymax(vp_ymax),
        .busy(busy), .err_valid(err_valid), .err_code(err_code), .cmd_count(cmd_count)
    );

    always @(negedge clk) begin
        if (eng_start != 4'd0) begin
            starts++;
            last_start = eng_start;
        end
        if (err_valid) begin
            errs++;
            last_err = err_code;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic bit m_legal(input logic [7:0] op);
        return (op >= 8'd1 && op <= 8'd4) || op == 8'h10 || op == 8'h11;
    endfunction

    function automatic logic [1:0] m_err(input logic [31:0] h);
        if (h[15:0] > 16'd8) return 2'd1;
        if (!m_legal(h[31:24])) return 2'd2;
        if ((h[31:24] == 8'h10 && h[15:0] < 16'd1) || (h[31:24] == 8'h11 && h[15:0] < 16'd4)) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [3:0] m_start(input logic [31:0] h);
        return (m_err(h) == 2'd0 && h[31:24] >= 8'd1 && h[31:24] <= 8'd4) ? 4'(1 << (h[31:24] - 8'd1)) : 4'd0;
    endfunction

    task automatic model_reset();
        m_color = '0;
        m_count = '0;
        m_len = '0;
        for (int i = 0; i < 4; i++) m_vp[i] = '0;
        for (int i = 0; i < 8; i++) m_words[i] = '0;
    endtask

    task automatic model_apply(input logic [31:0] h);
        int len = int'(h[15:0]);
        m_count = m_count + 16'd1;
        m_len = 16'd0;
        if (len <= 8 && m_legal(h[31:24])) begin
            m_len = h[15:0];
            for (int i = 0; i < len; i++) m_words[i] = wq[i];
        end
        if (m_err(h) == 2'd0 && h[31:24] == 8'h10) m_color = wq[0];
        if (m_err(h) == 2'd0 && h[31:24] == 8'h11)
            for (int i = 0; i < 4; i++) m_vp[i] = wq[i];
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_color"}, color, m_color);
        chk({tag, "_xmin"}, vp_xmin, m_vp[0]);
        chk({tag, "_ymin"}, vp_ymin, m_vp[1]);
        chk({tag, "_xmax"}, vp_xmax, m_vp[2]);
        chk({tag, "_ymax"}, vp_ymax, m_vp[3]);
        chk({tag, "_cmd_count"}, 32'(cmd_count), 32'(m_count));
        chk({tag, "_payload_len"}, 32'(payload_len), 32'(m_len));
        for (int i = 0; i < 8; i++) chk($sformatf("%s_payload%0d", tag, i), payload[i*32 +: 32], m_words[i]);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_eng_start"}, 32'(eng_start), 32'd0);
        chk({tag, "_err_valid"}, 32'(err_valid), 32'd0);
        chk({tag, "_err_code"}, 32'(err_code), 32'd0);
        chk({tag, "_cmd_count"}, 32'(cmd_count), 32'd0);
        chk({tag, "_payload_len"}, 32'(payload_len), 32'd0);
        chk({tag, "_color"}, color, 32'd0);
        chk({tag, "_viewport_nz"}, 32'(|{vp_xmin, vp_ymin, vp_xmax, vp_ymax}), 32'd0);
        chk({tag, "_payload_nz"}, 32'(|payload), 32'd0);
    endtask

    // Must be entered just after a rising edge.
    task automatic send_word(input logic [31:0] w, input bit gaps);
        int t = 0;
        bit acc = 1'b0;
        if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        cmd_valid = 1'b1;
        cmd_data = w;
        while (!acc && t < 64) begin
            @(negedge clk);
            acc = cmd_ready;
            @(posedge clk); #1;
            t++;
        end
        cmd_valid = 1'b0;
        chk("handshake", 32'(acc), 32'd1);
    endtask

    task automatic run_cmd(input logic [31:0] hdr, input logic [1:0] want_err, input logic [3:0] want_start,
                           input bit gaps);
        int len = int'(hdr[15:0]);
        int s0 = starts;
        int e0 = errs;
        int t = 0;
        @(posedge clk); #1;
        wq.delete();
        for (int i = 0; i < len; i++) wq.push_back($urandom);
        send_word(hdr, gaps);
        foreach (wq[i]) send_word(wq[i], gaps);
        do begin @(negedge clk); #1; t++; end while (busy && starts == s0 && t < 50);
        if (starts != s0) begin
            repeat ($urandom_range(0, 5)) begin @(posedge clk); #1; eng_done = 4'($urandom) & ~last_start; end
            @(negedge clk);
            chk("wait_ready_busy", {30'd0, cmd_ready, busy}, 32'd1);
            @(posedge clk); #1; eng_done = last_start;
            @(posedge clk); #1; eng_done = '0;
            t = 0;
            while (busy && t < 20) begin @(negedge clk); #1; t++; end
        end
        chk("idle_after", 32'(busy), 32'd0);
        chk("err_pulses", 32'(errs - e0), 32'(want_err != 2'd0));
        if (want_err != 2'd0) chk("err_code", 32'(last_err), 32'(want_err));
        chk("start_pulses", 32'(starts - s0), 32'(want_start != 4'd0));
        if (want_start != 4'd0) chk("start_vec", 32'(last_start), 32'(want_start));
        model_apply(hdr);
        check_state($sformatf("cmd_%h", hdr));
    endtask

    initial begin
        int n, e0;
        logic [7:0] op;
        logic [31:0] h;
        vt = '{
            '{32'h10000001, 2'd0, 4'b0000}, '{32'h02000006, 2'd0, 4'b0010}, '{32'h01000009, 2'd1, 4'b0000},
            '{32'h7F000002, 2'd2, 4'b0000}, '{32'h01000000, 2'd0, 4'b0001}, '{32'h11000004, 2'd0, 4'b0000},
            '{32'h11000002, 2'd2, 4'b0000}, '{32'h10000000, 2'd2, 4'b0000}, '{32'h05000001, 2'd2, 4'b0000},
            '{32'h00000000, 2'd2, 4'b0000}, '{32'h04000008, 2'd0, 4'b1000}, '{32'h12000009, 2'd1, 4'b0000},
            '{32'h03FF0003, 2'd0, 4'b0100}
        };
        model_reset();
        @(negedge clk);
        check_reset("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'(cmd_ready), 32'd1);

        // SET_COLOR: colour visible two edges after the payload word.
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_data = 32'h10000001;
        @(posedge clk); #1;
        cmd_data = 32'hFF00FF00;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("color_early", color, m_color);
        chk("color_start_busy", 32'(busy), 32'd1);
        chk("color_start_ready", 32'(cmd_ready), 32'd0);
        chk("color_no_eng_start", 32'(eng_start), 32'd0);
        @(negedge clk);
        chk("color_late", color, 32'hFF00FF00);
        chk("color_idle", 32'(busy), 32'd0);
        wq = '{32'hFF00FF00};
        model_apply(32'h10000001);
        check_state("color_seq");

        // Engine 0 with 2 words: start latency, done during START ignored.
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_data = 32'h01000002;
        @(posedge clk); #1;
        cmd_data = 32'h11111111;
        @(posedge clk); #1;
        cmd_data = 32'h22222222;
        @(negedge clk);
        chk("no_early_start", 32'(eng_start), 32'd0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        eng_done = 4'b0001;
        @(negedge clk);
        chk("start_cycle_vec", 32'(eng_start), 32'd1);
        chk("start_cycle_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        eng_done = '0;
        @(negedge clk);
        chk("early_done_ignored", 32'(busy), 32'd1);
        chk("start_single_cycle", 32'(eng_start), 32'd0);
        chk("wait_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        eng_done = 4'b0001;
        @(posedge clk); #1;
        eng_done = '0;
        @(negedge clk);
        chk("done_idle", 32'(busy), 32'd0);
        wq = '{32'h11111111, 32'h22222222};
        model_apply(32'h01000002);
        check_state("eng_seq");

        foreach (vt[i]) run_cmd(vt[i].hdr, vt[i].err, vt[i].start, 1'b0);

        // Engine 0 never completes.
        e0 = errs;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_data = 32'h01000000;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("to_start_vec", 32'(eng_start), 32'd1);
`ifdef CMD_DISPATCH_TIMEOUT_EN
        n = 0;
        do begin @(negedge clk); n++; end while (!err_valid && n < 200);
        chk("timeout_cycles", 32'(n), 32'd101);
        chk("timeout_code", 32'(err_code), 32'd3);
        @(negedge clk);
        chk("timeout_idle", 32'(busy), 32'd0);
        chk("timeout_pulses", 32'(errs - e0), 32'd1);
        wq.delete();
        model_apply(32'h01000000);
        check_state("timeout");
`else
        repeat (150) @(negedge clk);
        chk("hold_busy", 32'(busy), 32'd1);
        chk("no_timeout_err", 32'(errs - e0), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_reset("wait_rst");
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
`endif

        // Reset after 3 of 6 payload words.
        @(posedge clk); #1;
        send_word(32'h02000006, 1'b0);
        for (int i = 0; i < 3; i++) send_word($urandom, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset("mid_rst");
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
        run_cmd(32'h02000006, 2'd0, 4'b0010, 1'b0);

        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 3))
                0: op = 8'($urandom_range(1, 6));
                1: op = 8'h10;
                2: op = 8'h11;
                default: op = 8'($urandom);
            endcase
            h = {op, 8'($urandom), 16'($urandom_range(0, 10))};
            run_cmd(h, m_err(h), m_start(h), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
